mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Sequencer for the MEM stage of the 5-stage RISC-V pipeline. Sits between the EX/MEM buffer outputs and a variable-latency data memory with a req/ack handshake. Issues loads and stores, stalls every pipeline buffer while an access is outstanding, and captures load data for the MEM/WB buffer. It also resolves taken branches into a PC-select and a pipeline flush.

## Interface
- N, 64, datapath / address width
- TIMEOUT, 255, max cycles an access may wait for ack before abort (≥1)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- memRead_i  in  1  load request from EX/MEM buffer
- memWrite_i  in  1  store request from EX/MEM buffer
- branch_i  in  1  branch instruction in MEM
- zeroALU_i  in  1  ALU zero flag from EX/MEM buffer
- addr_i  in  N  ALU result (memory address)
- wdata_i  in  N  store data
- dmem_req  out  1  access request to data memory
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req
- dmem_addr  out  N  access address; valid while dmem_req
- dmem_wdata  out  N  store data; valid while dmem_req && dmem_we
- dmem_ack  in  1  memory completion; one-cycle pulse
- dmem_rdata  in  N  load data; valid with dmem_ack on reads
- stall  out  1  hold PC and all pipeline buffers this cycle
- flush  out  1  clear IF/ID, ID/EX, EX/MEM at next edge
- pcSrc  out  1  select pcBranch as next PC
- readData  out  N  registered load result for MEM/WB
- memErr  out  1  sticky: an access timed out

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE
  - If memRead_i | memWrite_i: stall=1.
  - Latch addr_i, wdata_i, we=memWrite_i into the dmem_* registers, set dmem_req=1, clear the wait counter, go to ACCESS.
  - If both memRead_i and memWrite_i are set, the write wins.
- ACCESS
  - stall=1, dmem_req held at 1, outputs stable, counter increments each cycle.
  - On dmem_ack: dmem_req←0. On reads, readData←dmem_rdata; on writes, readData is unchanged. Go to DONE.
  - If the counter reaches TIMEOUT without ack: dmem_req←0, memErr←1, readData←0 on reads, go to DONE.
- DONE
  - stall=0; the instruction leaves MEM at this edge. Always go to IDLE.
  - No new access is started from DONE, because the same instruction is still in EX/MEM.
- Branch: pcSrc = flush = branch_i & zeroALU_i & ~stall. Evaluated in IDLE and DONE only; forced 0 in ACCESS.
- dmem_ack outside ACCESS is ignored.
- memErr clears only on rst.

## Timing
- Registered outputs: dmem_req, dmem_we, dmem_addr, dmem_wdata, readData, memErr.
- Combinational outputs: stall, flush, pcSrc.
- Reset values: every registered output is 0 and state = IDLE. Combinational outputs evaluate to 0 in IDLE with no request.
- Access timeline, request seen in cycle 0:
  - dmem_req rises in cycle 1.
  - Earliest ack is in cycle 1, giving DONE in cycle 2.
  - A memory op occupies MEM for ≥3 cycles; a non-memory op occupies it for 1 cycle.
- stall is high from cycle 0 through the ack cycle inclusive, and low in DONE.
- readData is valid from the DONE cycle and holds until the next completed read.
- Timeout: with no ack, dmem_req is high for TIMEOUT cycles and drops at the following edge; memErr rises at that same edge.
- Reset mid-access: at the rst edge, dmem_req←0 and state←IDLE. The memory must tolerate an abandoned request, and a later ack is ignored.
- Back-to-back memory ops: the second op is seen in the IDLE cycle after DONE. There is no bubble beyond the DONE cycle.

## Structure
- Shared package pipe_pkg:
  - typedef enum logic [1:0] mem_state_t {IDLE, ACCESS, DONE}
  - localparam DMEM_TIMEOUT_DEFAULT = 255
- Sub-module wait_counter:
  - Ports: clr, en, count, done; width $clog2(TIMEOUT+1).
  - Instantiated once for the timeout.
- Remainder is one always_ff for state and output registers, plus one always_comb for next-state, stall, flush and pcSrc.

## Test plan
- Load, ack on first req cycle, dmem_rdata=64'hDEAD_BEEF:
  - dmem_req high 1 cycle, dmem_we=0, stall high 2 cycles.
  - readData=64'hDEAD_BEEF in DONE; state IDLE after 3 cycles.
- Store addr=0x40, wdata=0x1234, ack after 5 cycles:
  - dmem_we=1 and dmem_addr/dmem_wdata stable for all 5 req cycles.
  - stall high 6 cycles; readData unchanged.
- TIMEOUT=4, load, no ack:
  - req high 4 cycles, memErr=1, readData=0.
  - A subsequent acked load still completes, and memErr stays 1.
- branch_i=1, zeroALU_i=1 in IDLE → flush=pcSrc=1 same cycle.
- Same branch while in ACCESS → flush=pcSrc=0.
- rst asserted in the 2nd ACCESS cycle, then ack pulsed → all outputs 0 after the edge; the ack is ignored; readData remains 0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared types and constants for the 5-stage pipeline MEM stage.
//             Holds the MEM-stage sequencer state encoding and the default
//             data-memory timeout.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam int DMEM_TIMEOUT_DEFAULT = 255;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
// ============================================================================
//  Module   : wait_counter
//  Purpose  : Counts the cycles a data-memory request has been outstanding
//             and flags when TIMEOUT cycles have elapsed.
//  Ports    : clk, rst    - clock, synchronous active-high reset
//             clr         - return count to zero
//             en          - advance count by one (saturates at TIMEOUT)
//             count       - current cycle count
//             done        - count has reached TIMEOUT
//  Revision : 1.0 - initial release
// ============================================================================
module wait_counter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && !done) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
    assign done  = (r_count == c_LIMIT);

endmodule : wait_counter
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ctrl
//  Purpose  : MEM-stage sequencer. Issues loads/stores to a variable-latency
//             data memory over a req/ack handshake, stalls the pipeline while
//             an access is outstanding, captures load data for MEM/WB, aborts
//             accesses that wait TIMEOUT cycles, and resolves taken branches.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             memRead_i, memWrite_i    - load / store request from EX/MEM
//             branch_i, zeroALU_i      - branch in MEM and ALU zero flag
//             addr_i, wdata_i          - access address and store data
//             dmem_req/we/addr/wdata   - registered request to data memory
//             dmem_ack, dmem_rdata     - completion pulse and load data
//             stall, flush, pcSrc      - combinational pipeline controls
//             readData                 - registered load result
//             memErr                   - sticky access-timeout flag
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         memRead_i,
    input  logic         memWrite_i,
    input  logic         branch_i,
    input  logic         zeroALU_i,
    input  logic [N-1:0] addr_i,
    input  logic [N-1:0] wdata_i,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    output logic [N-1:0] dmem_wdata,
    input  logic         dmem_ack,
    input  logic [N-1:0] dmem_rdata,
    output logic         stall,
    output logic         flush,
    output logic         pcSrc,
    output logic [N-1:0] readData,
    output logic         memErr
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t         r_state;
    mem_state_t         w_next_state;
    logic               r_req;
    logic               r_we;
    logic [N-1:0]       r_addr;
    logic [N-1:0]       r_wdata;
    logic [N-1:0]       r_rdata;
    logic               r_err;

    logic               w_start;
    logic               w_in_access;
    logic               w_stall;
    logic               w_taken;
    logic               w_cnt_done;
    logic               w_timeout;
    // The sequencer only needs the terminal flag, not the running count.
    logic [c_CNT_W-1:0] w_wait_count_unused;

    // Counter runs from the request cycle onward, so in the k-th ACCESS
    // cycle it reads k and done marks the TIMEOUT-th cycle with req high.
    wait_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (c_CNT_W)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (!(w_start || w_in_access)),
        .en    (w_start || w_in_access),
        .count (w_wait_count_unused),
        .done  (w_cnt_done)
    );

    assign w_in_access = (r_state == ACCESS);
    assign w_timeout   = w_in_access && w_cnt_done;

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (memRead_i || memWrite_i) begin
                    w_stall      = 1'b1;
                    w_start      = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                w_stall = 1'b1;
                if (dmem_ack || w_timeout) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // Same instruction is still in EX/MEM; never restart here.
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        w_taken = branch_i && zeroALU_i && !w_stall && !w_in_access;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_req   <= 1'b1;
                        r_we    <= memWrite_i;   // write wins over read
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                    end
                end
                ACCESS: begin
                    // A late ack in the timeout cycle still counts as success.
                    if (dmem_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= dmem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_req <= 1'b0;
                        r_err <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign readData   = r_rdata;
    assign memErr     = r_err;
    assign stall      = w_stall;
    assign flush      = w_taken;
    assign pcSrc      = w_taken;

endmodule : mem_stage_ctrl
`default_nettype wire
